// File: rtl/synchro_register_arbiter.sv
// Round-robin arbiter that lets two requesters share the ZEROES/ONES fill
// commands of one synchro_register, with a fixed command width and idle gap.
module synchro_register_arbiter #(
    parameter int HOLD = 2,
    parameter int GAP  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_A,
    input  logic       OP_A,
    input  logic       REQ_B,
    input  logic       OP_B,
    output logic       ACK_A,
    output logic       ACK_B,
    output logic       ZEROES,
    output logic       ONES,
    output logic       BUSY,
    output logic       GRANT,
    output logic [1:0] dbg_state
);

    localparam int MAXP = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXP) + 1;

    generate
        if (HOLD < 1 || GAP < 1) begin : g_bad_param
            $error("synchro_register_arbiter: HOLD and GAP must both be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Handshake: REQ_x is a level held until the one-cycle ACK_x pulse;
    // REQ/OP are only sampled in IDLE, so a requester may drop REQ any time
    // after it observes ACK and before the gap ends.
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pri, pri_n;
    logic            op_q, op_n;
    logic            grant_n, take_b;
    logic            zeroes_n, ones_n, ack_a_n, ack_b_n;

    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pri    <= 1'b0;
            op_q   <= 1'b0;
            GRANT  <= 1'b0;
            ZEROES <= 1'b0;
            ONES   <= 1'b0;
            ACK_A  <= 1'b0;
            ACK_B  <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pri    <= pri_n;
            op_q   <= op_n;
            GRANT  <= grant_n;
            ZEROES <= zeroes_n;
            ONES   <= ones_n;
            ACK_A  <= ack_a_n;
            ACK_B  <= ack_b_n;
            BUSY   <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pri_n    = pri;
        op_n     = op_q;
        grant_n  = GRANT;
        take_b   = 1'b0;
        zeroes_n = 1'b0;
        ones_n   = 1'b0;
        ack_a_n  = 1'b0;
        ack_b_n  = 1'b0;
        case (state)
            S_IDLE: begin
                grant_n = 1'b0;
                if (REQ_A || REQ_B) begin
                    // pri == 1 means B has priority on a tie
                    take_b   = REQ_B && (!REQ_A || pri);
                    grant_n  = take_b;
                    op_n     = take_b ? OP_B : OP_A;
                    pri_n    = !take_b;
                    cnt_n    = CW'(HOLD - 1);
                    state_n  = S_DRIVE;
                    ones_n   = op_n;
                    zeroes_n = !op_n;
                end
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    state_n = S_GAP;
                    cnt_n   = CW'(GAP - 1);
                    ack_a_n = !GRANT;
                    ack_b_n = GRANT;
                end else begin
                    cnt_n    = cnt - CW'(1);
                    ones_n   = op_q;
                    zeroes_n = !op_q;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    grant_n = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_synchro_register_arbiter.sv
// Bench for synchro_register_arbiter: three parameterisations share one stimulus
// stream and are checked every cycle against a time-offset transaction model.
module tb_synchro_register_arbiter;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic REQ_A = 1'b0, OP_A = 1'b0, REQ_B = 1'b0, OP_B = 1'b0;
    logic [2:0] ack_a, ack_b, zeroes, ones, busy, grant;
    logic [1:0] dbg0, dbg1, dbg2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int   hold_p [3] = '{2, 1, 4};
    int   gap_p  [3] = '{1, 3, 1};
    bit   m_active [3];
    int   m_start  [3];
    bit   m_own [3];
    bit   m_op  [3];
    bit   m_pri [3];
    logic [7:0] exp_v [3];
    logic [3:0] bus_dut [3];
    logic [3:0] bus_exp [3];

    always #5 CLK = ~CLK;

    synchro_register_arbiter #(.HOLD(2), .GAP(1)) dut0 (
        .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
        .ACK_A(ack_a[0]), .ACK_B(ack_b[0]), .ZEROES(zeroes[0]), .ONES(ones[0]),
        .BUSY(busy[0]), .GRANT(grant[0]), .dbg_state(dbg0)
    );
    synchro_register_arbiter #(.HOLD(1), .GAP(3)) dut1 (
        .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
        .ACK_A(ack_a[1]), .ACK_B(ack_b[1]), .ZEROES(zeroes[1]), .ONES(ones[1]),
        .BUSY(busy[1]), .GRANT(grant[1]), .dbg_state(dbg1)
    );
    synchro_register_arbiter #(.HOLD(4), .GAP(1)) dut2 (
        .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .OP_A(OP_A), .REQ_B(REQ_B), .OP_B(OP_B),
        .ACK_A(ack_a[2]), .ACK_B(ack_b[2]), .ZEROES(zeroes[2]), .ONES(ones[2]),
        .BUSY(busy[2]), .GRANT(grant[2]), .dbg_state(dbg2)
    );

    task automatic check(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, expv);
        end
    endtask

    // A transaction granted at edge s drives its command after edges s..s+HOLD-1,
    // acks after s+HOLD and frees the arbiter after s+HOLD+GAP.
    task automatic model_edge(input int i);
        bit b;
        int d;
        if (RESET) begin
            m_active[i] = 1'b0;
            m_pri[i]    = 1'b0;
        end else begin
            if (m_active[i] && (cyc - m_start[i] > hold_p[i] + gap_p[i]))
                m_active[i] = 1'b0;
            if (!m_active[i] && (REQ_A || REQ_B)) begin
                b           = REQ_B && (!REQ_A || m_pri[i]);
                m_own[i]    = b;
                m_op[i]     = b ? OP_B : OP_A;
                m_pri[i]    = !b;
                m_active[i] = 1'b1;
                m_start[i]  = cyc;
            end
        end
        d = cyc - m_start[i];
        exp_v[i] = 8'h00;
        if (m_active[i] && d < hold_p[i] + gap_p[i]) begin
            exp_v[i][5] = (d < hold_p[i]) && !m_op[i];
            exp_v[i][4] = (d < hold_p[i]) && m_op[i];
            exp_v[i][3] = (d == hold_p[i]) && !m_own[i];
            exp_v[i][2] = (d == hold_p[i]) && m_own[i];
            exp_v[i][1] = 1'b1;
            exp_v[i][0] = m_own[i];
        end
    endtask

    function automatic logic [3:0] reg_next(input logic [3:0] cur, input logic z, input logic o);
        if (z) return 4'b0000;
        if (o) return 4'b1111;
        return cur;
    endfunction

    task automatic step();
        @(posedge CLK);
        cyc++;
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("outputs", i, {2'b00, zeroes[i], ones[i], ack_a[i], ack_b[i], busy[i], grant[i]}, exp_v[i]);
            check("bus", i, {4'h0, bus_dut[i]}, {4'h0, bus_exp[i]});
            bus_dut[i] = reg_next(bus_dut[i], zeroes[i], ones[i]);
            bus_exp[i] = reg_next(bus_exp[i], exp_v[i][5], exp_v[i][4]);
        end
    endtask

    initial begin : main
        int  width;
        int  cnt_a, cnt_b;
        bit  seen_a, seen_b, a_first;
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 0; m_start[i] = 0; m_own[i] = 0; m_op[i] = 0; m_pri[i] = 0;
            exp_v[i] = 8'h00; bus_dut[i] = 4'h0; bus_exp[i] = 4'h0;
        end

        // reset then idle
        RESET = 1'b1;
        repeat (5) step();
        RESET = 1'b0;
        repeat (10) step();

        // single A ONES request
        REQ_A = 1'b1; OP_A = 1'b1;
        width = 0; seen_a = 0;
        for (int t = 0; t < 20 && !seen_a; t++) begin
            step();
            if (ones[0]) width++;
            if (ack_a[0]) begin seen_a = 1; REQ_A = 1'b0; end
        end
        check("ack_a_seen", 0, {7'd0, seen_a}, 8'd1);
        check("ones_width", 0, 8'(width), 8'(hold_p[0]));
        repeat (3) step();
        check("bus_ones", 0, {4'h0, bus_dut[0]}, 8'h0f);

        // simultaneous after reset: A ONES then B ZEROES
        RESET = 1'b1; step(); RESET = 1'b0;
        REQ_A = 1'b1; OP_A = 1'b1; REQ_B = 1'b1; OP_B = 1'b0;
        seen_a = 0; seen_b = 0; a_first = 0;
        for (int t = 0; t < 30 && !(seen_a && seen_b); t++) begin
            step();
            if (ack_a[0]) begin seen_a = 1; REQ_A = 1'b0; a_first = !seen_b; end
            if (ack_b[0]) begin seen_b = 1; REQ_B = 1'b0; end
        end
        check("both_acked", 0, {6'd0, seen_a, seen_b}, 8'h03);
        check("a_served_first", 0, {7'd0, a_first}, 8'd1);
        repeat (3) step();
        check("bus_zeroes", 0, {4'h0, bus_dut[0]}, 8'h00);

        // fairness with both held permanently
        REQ_A = 1'b1; REQ_B = 1'b1; OP_A = 1'b0; OP_B = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (16) begin
            step();
            if (ack_a[0]) cnt_a++;
            if (ack_b[0]) cnt_b++;
        end
        check("fair_acks_a", 0, 8'(cnt_a), 8'd2);
        check("fair_acks_b", 0, 8'(cnt_b), 8'd2);
        REQ_A = 1'b0; REQ_B = 1'b0;
        repeat (8) step();

        // reset in the second DRIVE cycle of an A request
        REQ_A = 1'b1; OP_A = 1'b1;
        step();
        RESET = 1'b1;
        step();
        check("abort_ones", 0, {7'd0, ones[0]}, 8'd0);
        check("abort_busy", 0, {7'd0, busy[0]}, 8'd0);
        RESET = 1'b0; REQ_B = 1'b1; OP_B = 1'b0;
        step();
        check("pri_reset_grant", 0, {6'd0, busy[0], grant[0]}, 8'h02);
        REQ_A = 1'b0; REQ_B = 1'b0;
        repeat (8) step();

        // randomized traffic with handshaking requesters and occasional reset
        for (int t = 0; t < 400; t++) begin
            RESET = ($urandom_range(0, 39) == 0);
            if (REQ_A && ack_a[0]) REQ_A = 1'b0;
            else if (!REQ_A && $urandom_range(0, 2) == 0) begin
                REQ_A = 1'b1; OP_A = 1'($urandom_range(0, 1));
            end
            if (REQ_B && ack_b[0]) REQ_B = 1'b0;
            else if (!REQ_B && $urandom_range(0, 2) == 0) begin
                REQ_B = 1'b1; OP_B = 1'($urandom_range(0, 1));
            end
            step();
        end
        RESET = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
